// File: rtl/spi_drv_arbiter.sv
// spi_drv_arbiter
//   Shares one spi_drv core between N_REQ requesters using round-robin
//   arbitration. The winner's command is latched and launched with a single
//   start_cmd pulse. The arbiter then follows the spi_drv_rdy busy/idle
//   handshake and returns the received word together with a one-cycle done
//   strobe to the requester that owned the transfer.
//
// Ports
//   clk, rst        system clock; synchronous active-high reset
//   req             per-requester level request, held until done
//   req_n_clks      packed bit counts, slice i = [i*CW +: CW]
//   req_tx_data     packed tx words, slice i = [i*SPI_MAXLEN +: SPI_MAXLEN]
//   done            one-hot, one-cycle completion strobe
//   err             valid with done: command rejected or core never started
//   rx_data         valid with done: captured rx_miso (0 on err)
//   grant_id        index of the current or last granted requester
//   cs_sel          one-hot slave select for the top-level SS_N routing
//   spi_start_cmd   one-cycle start pulse to spi_drv
//   spi_n_clks      latched bit count to spi_drv
//   spi_tx_data     latched tx word to spi_drv
//   spi_rdy         spi_drv idle indication (1 = idle)
//   spi_rx_miso     spi_drv received word

module spi_drv_arbiter #(
   parameter int N_REQ         = 4,
   parameter int SPI_MAXLEN    = 8,
   parameter int START_TIMEOUT = 16,
   localparam int CW = $clog2(SPI_MAXLEN) + 1,
   localparam int IW = $clog2(N_REQ)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [N_REQ-1:0]              req,
   input  logic [N_REQ*CW-1:0]           req_n_clks,
   input  logic [N_REQ*SPI_MAXLEN-1:0]   req_tx_data,
   output logic [N_REQ-1:0]              done,
   output logic                          err,
   output logic [SPI_MAXLEN-1:0]         rx_data,
   output logic [IW-1:0]                 grant_id,
   output logic [N_REQ-1:0]              cs_sel,
   output logic                          spi_start_cmd,
   output logic [CW-1:0]                 spi_n_clks,
   output logic [SPI_MAXLEN-1:0]         spi_tx_data,
   input  logic                          spi_rdy,
   input  logic [SPI_MAXLEN-1:0]         spi_rx_miso
);

   localparam int TW = $clog2(START_TIMEOUT) + 1;

   typedef enum logic [2:0] {
      IDLE,
      LAUNCH,
      WAIT_BUSY,
      WAIT_DONE,
      RESP
   } state_t;

   state_t                state;
   state_t                state_next;
   logic [IW-1:0]         rr_ptr;
   logic [TW-1:0]         tmo_cnt;
   logic [IW-1:0]         win_id;
   logic [IW-1:0]         scan_idx;
   logic                  win_found;
   logic [CW-1:0]         win_n_clks;
   logic [SPI_MAXLEN-1:0] win_tx_data;
   logic                  win_valid;
   logic                  arb_go;
   logic                  timeout_hit;

   // Round-robin search. The loop walks from the farthest offset back to
   // rr_ptr itself so the last hit written is the closest requester at or
   // after the pointer, which gives the round-robin priority order.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      scan_idx  = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         scan_idx = IW'((int'(rr_ptr) + k) % N_REQ);
         if (req[scan_idx]) begin
            win_found = 1'b1;
            win_id    = scan_idx;
         end
      end
   end

   // Command of the current winner plus the qualifiers shared by the
   // next-state logic and the datapath registers.
   always_comb begin
      win_n_clks  = req_n_clks[int'(win_id) * CW +: CW];
      win_tx_data = req_tx_data[int'(win_id) * SPI_MAXLEN +: SPI_MAXLEN];
      win_valid   = (win_n_clks != '0) && (win_n_clks <= CW'(SPI_MAXLEN));
      arb_go      = (state == IDLE) && spi_rdy && win_found;
      // The counter holds the number of WAIT_BUSY cycles already spent with
      // spi_rdy high; reaching START_TIMEOUT-1 on this cycle means done
      // lands exactly START_TIMEOUT cycles after the start pulse.
      timeout_hit = (state == WAIT_BUSY) && spi_rdy &&
                    (tmo_cnt == TW'(START_TIMEOUT - 2));
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. A rejected command skips the core entirely and goes
   // straight to the response cycle.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (arb_go) begin
               state_next = win_valid ? LAUNCH : RESP;
            end
         end
         LAUNCH:    state_next = WAIT_BUSY;
         WAIT_BUSY: begin
            if (!spi_rdy) begin
               state_next = WAIT_DONE;
            end else if (timeout_hit) begin
               state_next = RESP;
            end
         end
         WAIT_DONE: begin
            if (spi_rdy) begin
               state_next = RESP;
            end
         end
         RESP:      state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   // Strobe outputs are decoded straight from the state so they are exactly
   // one cycle wide and drop to zero as soon as reset forces IDLE.
   always_comb begin
      done          = '0;
      spi_start_cmd = 1'b0;
      if (state == RESP) begin
         done[grant_id] = 1'b1;
      end
      if (state == LAUNCH) begin
         spi_start_cmd = 1'b1;
      end
   end

   // Datapath registers: latched command, slave select, result and the
   // round-robin pointer. The command is captured only at grant time so
   // later changes on the requester side cannot disturb a running transfer.
   always_ff @(posedge clk) begin
      if (rst) begin
         grant_id    <= '0;
         spi_n_clks  <= '0;
         spi_tx_data <= '0;
         cs_sel      <= '0;
         err         <= 1'b0;
         rx_data     <= '0;
         rr_ptr      <= '0;
         tmo_cnt     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (arb_go) begin
                  grant_id    <= win_id;
                  spi_n_clks  <= win_n_clks;
                  spi_tx_data <= win_tx_data;
                  if (win_valid) begin
                     cs_sel <= N_REQ'(1) << win_id;
                  end else begin
                     err     <= 1'b1;
                     rx_data <= '0;
                  end
               end
            end
            LAUNCH: begin
               tmo_cnt <= '0;
            end
            WAIT_BUSY: begin
               if (timeout_hit) begin
                  err     <= 1'b1;
                  rx_data <= '0;
               end else if (spi_rdy) begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            WAIT_DONE: begin
               if (spi_rdy) begin
                  rx_data <= spi_rx_miso;
                  err     <= 1'b0;
               end
            end
            RESP: begin
               cs_sel <= '0;
               rr_ptr <= (grant_id == IW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
            end
            default: begin
               cs_sel <= '0;
            end
         endcase
      end
   end

endmodule
